// File: rtl/threshold2_div_pkg.sv
// Shared widths, state encoding and helpers for the threshold2 sequential divider.
// Optional rounding is enabled by defining THRESHOLD2_DIV_ROUND_EN.
package threshold2_div_pkg;

  localparam int DIVIDEND_WIDTH = 28;
  localparam int DIVISOR_WIDTH  = 8;
  localparam int QUOTIENT_WIDTH = 20;
  localparam int CNT_WIDTH      = $clog2(QUOTIENT_WIDTH);

  localparam logic [QUOTIENT_WIDTH-1:0] QUOT_MAX = {QUOTIENT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]      CNT_LAST = CNT_WIDTH'(QUOTIENT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // The quotient cannot fit in QUOTIENT_WIDTH bits when the upper dividend
  // slice already reaches the divisor, or when the divisor is zero.
  function automatic logic div_early_ovf(input logic [DIVISOR_WIDTH-1:0] hi,
                                         input logic [DIVISOR_WIDTH-1:0] dv);
    return (dv == {DIVISOR_WIDTH{1'b0}}) || (hi >= dv);
  endfunction

endpackage

// File: rtl/threshold2_div_seq_if.sv
// Operand/result handshake bundle for threshold2_div_seq.
// master = upstream/downstream environment, slave = divider.
interface threshold2_div_seq_if;
  import threshold2_div_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [QUOTIENT_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf
  );
endinterface

// File: rtl/threshold2_div_step.sv
// One combinational restoring-division step: shift in one dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module threshold2_div_step
  import threshold2_div_pkg::*;
(
  input  logic [DIVISOR_WIDTH:0]   rem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [DIVISOR_WIDTH:0]   rem_o,
  output logic                     q_o
);

  logic [DIVISOR_WIDTH+1:0] t_s;

  // trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    t_s = {rem_i, bit_i};
    if (t_s >= {2'b00, divisor_i}) begin
      q_o   = 1'b1;
      rem_o = (DIVISOR_WIDTH+1)'(t_s - {2'b00, divisor_i});
    end else begin
      q_o   = 1'b0;
      rem_o = t_s[DIVISOR_WIDTH:0];
    end
  end

endmodule

// File: rtl/threshold2_div_seq.sv
// Sequential unsigned restoring divider (28 / 8 -> 20-bit quotient, 8-bit remainder).
// Optional round-to-nearest on the quotient when THRESHOLD2_DIV_ROUND_EN is defined.
module threshold2_div_seq
  import threshold2_div_pkg::*;
(
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  threshold2_div_seq_if.slave  bus
);

  state_e                    state_q, state_d;
  logic [DIVISOR_WIDTH:0]    rem_q, rem_d;
  logic [QUOTIENT_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
  logic [QUOTIENT_WIDTH-1:0] quotient_q, quotient_d;
  logic [DIVISOR_WIDTH-1:0]  remainder_q, remainder_d;
  logic                      ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  logic [DIVISOR_WIDTH:0]    step_rem_s;
  logic                      step_q_s;
  logic [QUOTIENT_WIDTH-1:0] fin_quot_s;

  // The shift register feeds dividend bits from its MSB and collects quotient
  // bits at its LSB, so after the last step it holds the full quotient.
  threshold2_div_step u_step (
    .rem_i     (rem_q),
    .bit_i     (shift_q[QUOTIENT_WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // next-state and result computation
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    fin_quot_s  = {shift_q[QUOTIENT_WIDTH-2:0], step_q_s};

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          divisor_d  = bus.divisor;
          in_ready_d = 1'b0;
          if (div_early_ovf(bus.dividend[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH], bus.divisor)) begin
            state_d     = DONE;
            ovf_d       = 1'b1;
            quotient_d  = QUOT_MAX;
            remainder_d = {DIVISOR_WIDTH{1'b0}};
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
            rem_d   = {1'b0, bus.dividend[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH]};
            shift_d = bus.dividend[QUOTIENT_WIDTH-1:0];
            cnt_d   = {CNT_WIDTH{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        rem_d   = step_rem_s;
        shift_d = fin_quot_s;
        cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          remainder_d = step_rem_s[DIVISOR_WIDTH-1:0];
          ovf_d       = 1'b0;
`ifdef THRESHOLD2_DIV_ROUND_EN
          // round half up; the remainder output stays truncated
          if ({step_rem_s, 1'b0} >= {2'b00, divisor_q}) begin
            if (fin_quot_s == QUOT_MAX) begin
              quotient_d = QUOT_MAX;
              ovf_d      = 1'b1;
            end else begin
              quotient_d = fin_quot_s + {{(QUOTIENT_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            quotient_d = fin_quot_s;
          end
`else
          quotient_d = fin_quot_s;
`endif
        end else begin
          state_d = CALC;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      rem_q       <= {(DIVISOR_WIDTH+1){1'b0}};
      shift_q     <= {QUOTIENT_WIDTH{1'b0}};
      cnt_q       <= {CNT_WIDTH{1'b0}};
      divisor_q   <= {DIVISOR_WIDTH{1'b0}};
      quotient_q  <= {QUOTIENT_WIDTH{1'b0}};
      remainder_q <= {DIVISOR_WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_threshold2_div_seq.sv
// Self-checking bench for threshold2_div_seq: directed cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_threshold2_div_seq;
  import threshold2_div_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;

  threshold2_div_seq_if bus();

  threshold2_div_seq dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [27:0] dd;
    logic [7:0]  dv;
    logic [19:0] q;
    logic [7:0]  r;
    logic        ovf;
    logic        early;
  } res_t;

  // reference: plain integer division, overflow when the quotient exceeds 20 bits
  function automatic res_t ref_div(input logic [27:0] dd, input logic [7:0] dv);
    res_t x;
    longint unsigned qf, rf;
    x.dd = dd;
    x.dv = dv;
    if (dv == 8'd0) begin
      qf = 64'd0; rf = 64'd0;
    end else begin
      qf = longint'(dd) / longint'(dv);
      rf = longint'(dd) % longint'(dv);
    end
    x.early = (dv == 8'd0) || (qf > 64'hFFFFF);
    if (x.early) begin
      x.q = 20'hFFFFF; x.r = 8'd0; x.ovf = 1'b1;
    end else begin
      x.r = rf[7:0]; x.ovf = 1'b0;
`ifdef THRESHOLD2_DIV_ROUND_EN
      if (2 * rf >= longint'(dv)) begin
        if (qf == 64'hFFFFF) x.ovf = 1'b1;
        else qf = qf + 64'd1;
      end
`endif
      x.q = qf[19:0];
    end
    return x;
  endfunction

  res_t exp_q[$];
  int   cyc = 0;
  bit   busy = 1'b0;
  int   rdy_cyc = 0;
  int   n_acc = 0, n_done = 0, n_abort = 0;
  bit   started = 1'b0;

  // model update on each rising edge (inputs settle #1 after the edge)
  always @(posedge ap_clk) begin
    res_t x;
    cyc++;
    if (ap_rst) begin
      n_abort += exp_q.size();
      exp_q.delete();
      busy = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_done++;
        busy = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        x = ref_div(bus.dividend, bus.divisor);
        exp_q.push_back(x);
        n_acc++;
        busy = 1'b1;
        rdy_cyc = cyc + (x.early ? 0 : 20);
      end
    end
  end

  // compare process on the falling edge
  always @(negedge ap_clk) begin
    longint unsigned recon;
    if (started && !ap_rst) begin
      check("in_ready", bus.in_ready, !busy);
      check("out_valid", bus.out_valid, busy && (cyc >= rdy_cyc));
      if (bus.out_valid && exp_q.size() > 0) begin
        check("quotient", bus.quotient, exp_q[0].q);
        check("remainder", bus.remainder, exp_q[0].r);
        check("ovf", bus.ovf, exp_q[0].ovf);
`ifndef THRESHOLD2_DIV_ROUND_EN
        if (!bus.ovf) begin
          recon = longint'(bus.quotient) * longint'(exp_q[0].dv) + longint'(bus.remainder);
          check("invariant q*d+r", recon, longint'(exp_q[0].dd));
          check("invariant r<d", bus.remainder < exp_q[0].dv, 1'b1);
        end
`endif
      end
    end
  end

  task automatic run_op(input logic [27:0] dd, input logic [7:0] dv,
                        input logic [19:0] eq, input logic [7:0] er,
                        input logic eovf, input int elat);
    int lat;
    @(posedge ap_clk); #1;
    check("idle in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.dividend = dd; bus.divisor = dv; bus.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 28'($urandom);
    bus.divisor  = 8'($urandom);
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) break;
      @(posedge ap_clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check("directed quotient", bus.quotient, eq);
    check("directed remainder", bus.remainder, er);
    check("directed ovf", bus.ovf, eovf);
    @(posedge ap_clk); #1;
    check("post-handshake out_valid", bus.out_valid, 1'b0);
    check("post-handshake in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic wait_out_valid(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (bus.out_valid) break;
      @(posedge ap_clk); #1;
    end
    check("out_valid within budget", i < budget, 1'b1);
  endtask

  initial begin
    res_t  x;
    logic [7:0] dv, hi;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = 28'd0; bus.divisor = 8'd0;

    // pin the reference model with hand-computed values
    x = ref_div(28'd1000, 8'd7);
`ifdef THRESHOLD2_DIV_ROUND_EN
    check("model 1000/7 q", x.q, 20'd143);
`else
    check("model 1000/7 q", x.q, 20'd142);
`endif
    check("model 1000/7 r", x.r, 8'd6);
    x = ref_div(28'h0F00000, 8'd15);
    check("model ovf", {x.ovf, x.q}, {1'b1, 20'hFFFFF});

    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    started = 1'b1;
    check("reset quotient", bus.quotient, 20'd0);
    check("reset remainder", bus.remainder, 8'd0);
    check("reset ovf", bus.ovf, 1'b0);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset in_ready", bus.in_ready, 1'b1);

`ifdef THRESHOLD2_DIV_ROUND_EN
    run_op(28'd1000, 8'd7, 20'd143, 8'd6, 1'b0, 21);
`else
    run_op(28'd1000, 8'd7, 20'd142, 8'd6, 1'b0, 21);
`endif
    run_op(28'd267386625, 8'd255, 20'hFFFFF, 8'd0, 1'b0, 21);
    run_op(28'h0F00000, 8'd15, 20'hFFFFF, 8'd0, 1'b1, 1);
    run_op(28'd12345, 8'd0, 20'hFFFFF, 8'd0, 1'b1, 1);

    // backpressure, then an in_valid coincident with the handshake
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b1; bus.dividend = 28'd1000; bus.divisor = 8'd7; bus.out_ready = 1'b0;
    @(posedge ap_clk); #1;
    bus.dividend = 28'd500; bus.divisor = 8'd3;
    wait_out_valid(40);
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk); #1;
      check("bp in_ready", bus.in_ready, 1'b0);
      check("bp out_valid", bus.out_valid, 1'b1);
`ifdef THRESHOLD2_DIV_ROUND_EN
      check("bp quotient", bus.quotient, 20'd143);
`else
      check("bp quotient", bus.quotient, 20'd142);
`endif
      check("bp remainder", bus.remainder, 8'd6);
    end
    bus.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    check("no-skid in_ready", bus.in_ready, 1'b1);
    check("no-skid out_valid", bus.out_valid, 1'b0);
    @(posedge ap_clk); #1;
    check("accept after handshake", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    wait_out_valid(40);
    @(posedge ap_clk); #1;

    // reset in the middle of CALC
    bus.in_valid = 1'b1; bus.dividend = 28'd1000; bus.divisor = 8'd7;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check("abort out_valid", bus.out_valid, 1'b0);
    check("abort in_ready", bus.in_ready, 1'b1);
`ifdef THRESHOLD2_DIV_ROUND_EN
    run_op(28'd500, 8'd3, 20'd167, 8'd2, 1'b0, 21);
`else
    run_op(28'd500, 8'd3, 20'd166, 8'd2, 1'b0, 21);
`endif

    // randomized traffic with random backpressure
    for (int c = 0; c < 4000; c++) begin
      @(posedge ap_clk); #1;
      dv = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 15) == 0) dv = 8'd0;
      if ($urandom_range(0, 4) != 0 && dv != 8'd0) hi = 8'($urandom_range(0, int'(dv) - 1));
      else hi = 8'($urandom);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.divisor   = dv;
      bus.dividend  = {hi, 20'($urandom)};
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      @(posedge ap_clk); #1;
    end
    check("drained", busy, 1'b0);
    check("queue empty", exp_q.size(), 0);
    check("result count", n_done + n_abort, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/threshold2_div_seq.md
Name: threshold2_div_seq

Overview:
- Sequential unsigned restoring divider for the threshold2 HLS core. It is the inverse of the 20x8 -> 28-bit product path.
- Takes a 28-bit dividend (accumulated pixel sum) and an 8-bit divisor (pixel count or weight). Returns a 20-bit quotient and an 8-bit remainder.
- Valid/ready handshakes on both sides. Sits between the accumulator stage and the threshold comparator.

Parameters:
- DIVIDEND_WIDTH, 28: dividend width; equals QUOTIENT_WIDTH + DIVISOR_WIDTH.
- DIVISOR_WIDTH, 8: divisor and remainder width.
- QUOTIENT_WIDTH, 20: quotient width; also the number of iterations.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept an operand pair.
- dividend  in  DIVIDEND_WIDTH  unsigned numerator.
- divisor  in  DIVISOR_WIDTH  unsigned denominator.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- quotient  out  QUOTIENT_WIDTH  unsigned quotient.
- remainder  out  DIVISOR_WIDTH  unsigned remainder.
- ovf  out  1  quotient does not fit, or divide-by-zero.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, ovf=0, iteration counter=0.
- Reset while in CALC or DONE aborts the operation. Any pending result is discarded; nothing is emitted.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch the operands.
    - If divisor==0 or dividend[27:20] >= divisor, go to DONE with ovf=1, quotient=all ones, remainder=0.
    - Otherwise go to CALC. Partial remainder (DIVISOR_WIDTH+1 bits) = dividend[27:20]; shift register = dividend[19:0]; counter=0.
  - CALC: in_ready=0. Each cycle:
    - t = {rem, next MSB of shift register};
    - if t >= divisor: rem = t - divisor, quotient bit = 1; else rem = t, quotient bit = 0;
    - shift the quotient bit into the LSB.
    - After QUOTIENT_WIDTH cycles (counter == QUOTIENT_WIDTH-1), register the results and go to DONE.
  - DONE: out_valid=1; outputs held stable. When out_ready=1, go to IDLE and clear out_valid.
- Latency:
  - Normal case: input accepted at cycle 0; out_valid at cycle QUOTIENT_WIDTH+1 (21).
  - ovf case: out_valid at cycle 1.
- Throughput: one operation in flight. in_ready is low from the acceptance edge until the DONE->IDLE edge.
- No skid: an in_valid arriving in the same cycle as the DONE handshake is accepted only on the following cycle, when in_ready=1.
- out_ready held low: stay in DONE indefinitely; quotient, remainder and ovf must not change.
- Operands may change after acceptance without affecting the result.
- Invariant (no ovf): quotient*divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
- Macro: THRESHOLD2_DIV_ROUND_EN.
- Defined: on entry to DONE (non-ovf), if 2*remainder >= divisor then quotient = quotient+1.
  - If the increment would wrap past 2^20-1, quotient saturates at 2^20-1 and ovf=1.
  - remainder output stays the truncated remainder.
  - Latency unchanged.
- Undefined: truncating division only; no rounding logic is present.

Decomposition:
- Package threshold2_div_pkg:
  - width constants (DIVIDEND_WIDTH, DIVISOR_WIDTH, QUOTIENT_WIDTH);
  - derived counter width CNT_WIDTH = $clog2(QUOTIENT_WIDTH);
  - state enum typedef (IDLE, CALC, DONE);
  - QUOT_MAX constant.
- Sub-module threshold2_div_step: combinational single restoring step. Inputs: rem, incoming bit, divisor. Outputs: next rem, quotient bit. Instantiated once and reused per cycle by the FSM.

Test Plan:
- Basic: dividend=1000, divisor=7 -> after 21 cycles quotient=142, remainder=6, ovf=0. With THRESHOLD2_DIV_ROUND_EN: quotient=143, remainder=6.
- Max exact: dividend=267386625 (0xFFFFF*255), divisor=255 -> quotient=0xFFFFF, remainder=0, ovf=0.
- Overflow: dividend=0x0F00000, divisor=15 -> out_valid at cycle 1, ovf=1, quotient=0xFFFFF, remainder=0. Divisor=0 with any dividend gives the same response.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> one-cycle handshake, in_ready=1 next cycle.
- Reset mid-operation: assert ap_rst at cycle 10 of CALC -> next cycle state=IDLE, out_valid=0, in_ready=1. A new operation (500/3) then yields quotient=166, remainder=2.
- Randomized back-to-back operands with random out_ready -> every non-ovf result satisfies q*d+r==dividend and r<d; result count equals accepted-input count.
